// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for eight bus requesters with a registered one-hot grant,
// a hold-time limit under contention, and a data/control mux for the current owner.
module bus_rr_arbiter #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int MAX_HOLD   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            req,
  output logic [7:0]            ack,
  input  logic [BUS_WIDTH-1:0]  bus_in_0,
  input  logic [BUS_WIDTH-1:0]  bus_in_1,
  input  logic [BUS_WIDTH-1:0]  bus_in_2,
  input  logic [BUS_WIDTH-1:0]  bus_in_3,
  input  logic [BUS_WIDTH-1:0]  bus_in_4,
  input  logic [BUS_WIDTH-1:0]  bus_in_5,
  input  logic [BUS_WIDTH-1:0]  bus_in_6,
  input  logic [BUS_WIDTH-1:0]  bus_in_7,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_0,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_1,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_2,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_3,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_4,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_5,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_6,
  input  logic [CTRL_WIDTH-1:0] ctrl_in_7,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic [2:0]            owner,
  output logic                  busy
);

  // state | meaning
  // IDLE  | no grant; arbitrate req starting at ptr
  // GRANT | owner holds the bus until it drops req or the hold limit forces release

  // A zero MAX_HOLD still needs a 1-bit counter; it just never advances.
  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [2:0]       owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       ack_nxt;
  logic [2:0]       idx, pick;
  logic             found;
  logic             hold_expired;

  logic [BUS_WIDTH-1:0]  bus_arr  [8];
  logic [CTRL_WIDTH-1:0] ctrl_arr [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      ack   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    cnt_nxt      = cnt;
    ack_nxt      = ack;
    found        = 1'b0;
    pick         = ptr;
    idx          = ptr;
    hold_expired = (MAX_HOLD != 0) && (cnt == CNT_LAST);

    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    unique case (state)
      IDLE: begin
        if (found) begin
          owner_nxt = pick;
          ack_nxt   = 8'b1 << pick;
          cnt_nxt   = '0;
          ptr_nxt   = pick + 3'd1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // ack is one-hot(owner) here, so ~ack masks the owner out of the contention test.
        if (!req[owner]) begin
          ack_nxt   = '0;
          state_nxt = IDLE;
        end else if (hold_expired && ((req & ~ack) != 8'h00)) begin
          ack_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_arr[0]  = bus_in_0;   bus_arr[1]  = bus_in_1;
    bus_arr[2]  = bus_in_2;   bus_arr[3]  = bus_in_3;
    bus_arr[4]  = bus_in_4;   bus_arr[5]  = bus_in_5;
    bus_arr[6]  = bus_in_6;   bus_arr[7]  = bus_in_7;
    ctrl_arr[0] = ctrl_in_0;  ctrl_arr[1] = ctrl_in_1;
    ctrl_arr[2] = ctrl_in_2;  ctrl_arr[3] = ctrl_in_3;
    ctrl_arr[4] = ctrl_in_4;  ctrl_arr[5] = ctrl_in_5;
    ctrl_arr[6] = ctrl_in_6;  ctrl_arr[7] = ctrl_in_7;
    busy     = (state == GRANT);
    bus_out  = busy ? bus_arr[owner]  : '0;
    ctrl_out = busy ? ctrl_arr[owner] : '0;
  end

endmodule
